// File: rtl/dds_pkg.sv
// Shared constants and FSM state encoding for the DDS sweep sequencer.
package dds_pkg;

    localparam int IDX_W      = 7;
    localparam int DATA_W     = 32;
    localparam int DWELL_NONE = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_LUT  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DWELL     = 3'd5
    } dds_state_e;

endpackage

// File: rtl/dds_sweep_sequencer_if.sv
// Write handshake between the sweep sequencer (master) and the parallel-port bus engine (slave).
interface dds_sweep_sequencer_if;
    import dds_pkg::*;

    logic              wr_valid_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              wr_ready_i;
    logic              frame_done_i;

    modport master (
        output wr_valid_o,
        output wr_data_o,
        input  wr_ready_i,
        input  frame_done_i
    );

    modport slave (
        input  wr_valid_o,
        input  wr_data_o,
        output wr_ready_i,
        output frame_done_i
    );

endinterface

// File: rtl/dds_sweep_sequencer_dwell.sv
// Dwell down-counter: load with N, expires after N enabled clocks (N >= 1).
module dds_dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] r_cnt;

    // Loading N-1 lets the terminal-count compare fire on the Nth enabled clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= val_i - W'(1);
        end else if (en_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign expired_o = (r_cnt == '0);

endmodule

// File: rtl/dds_sweep_sequencer.sv
// DDS sweep sequencer: walks LUT indices, hands each word to the bus engine, dwells between steps.
// Build option DDS_SWEEP_PINGPONG_EN adds pingpong_i for a triangle sweep when looping.
module dds_sweep_sequencer
    import dds_pkg::*;
#(
    parameter int IDXW    = IDX_W,
    parameter int DWELLW  = 24,
    parameter int LUT_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  loop_i,
`ifdef DDS_SWEEP_PINGPONG_EN
    input  logic                  pingpong_i,
`endif
    input  logic [IDXW-1:0]       first_idx_i,
    input  logic [IDXW-1:0]       last_idx_i,
    input  logic [DWELLW-1:0]     dwell_i,
    output logic [IDXW-1:0]       lut_idx_o,
    input  logic [DATA_W-1:0]     lut_data_i,
    dds_sweep_sequencer_if.master wr,
    output logic                  busy_o,
    output logic                  step_o,
    output logic                  done_o,
    output logic                  err_o
);

    // state     | meaning
    // IDLE      | waiting for start_i
    // FETCH     | drive lut_idx_o with the current index
    // WAIT_LUT  | let the LUT read latency elapse, then capture the word
    // ISSUE     | wr_valid_o held until the engine accepts
    // WAIT_DONE | waiting for the engine's IO_update (frame_done_i)
    // DWELL     | idle for the programmed dwell before the next step
    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_FETCH     = ST_FETCH;
    localparam logic [2:0] S_WAIT_LUT  = ST_WAIT_LUT;
    localparam logic [2:0] S_ISSUE     = ST_ISSUE;
    localparam logic [2:0] S_WAIT_DONE = ST_WAIT_DONE;
    localparam logic [2:0] S_DWELL     = ST_DWELL;

    localparam logic [IDXW-1:0] ONE = IDXW'(1);

    logic [2:0]        r_state;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   r_first;
    logic [IDXW-1:0]   r_last;
    logic              r_loop;
    logic [DWELLW-1:0] r_dwell;
    logic [1:0]        r_lat;
    logic [IDXW-1:0]   r_lut_idx;
    logic              r_wr_valid;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_busy;
    logic              r_step;
    logic              r_done;
    logic              r_err;
`ifdef DDS_SWEEP_PINGPONG_EN
    logic              r_pp;
    logic              r_up;
    logic              w_nxt_up;
`endif

    logic              w_fd_take;
    logic              w_has_dwell;
    logic              w_dwell_load;
    logic              w_dwell_exp;
    logic              w_next_step;
    logic [IDXW-1:0]   w_nxt_idx;
    logic              w_nxt_end;

    assign w_fd_take    = (r_state == S_WAIT_DONE) && wr.frame_done_i;
    assign w_has_dwell  = (r_dwell != DWELLW'(DWELL_NONE));
    assign w_dwell_load = !abort_i && w_fd_take && w_has_dwell;
    assign w_next_step  = !abort_i && ((w_fd_take && !w_has_dwell) ||
                                       ((r_state == S_DWELL) && w_dwell_exp));

    dds_dwell_timer #(
        .W (DWELLW)
    ) u_dwell (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (abort_i),
        .load_i    (w_dwell_load),
        .val_i     (r_dwell),
        .en_i      (r_state == S_DWELL),
        .expired_o (w_dwell_exp)
    );

    // The range end is checked before incrementing, so an index at 2^IDXW-1 never wraps.
    always_comb begin
        w_nxt_idx = r_idx;
        w_nxt_end = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
        w_nxt_up  = r_up;
        if (r_pp && r_loop) begin
            if (r_first == r_last) begin
                w_nxt_idx = r_idx;
            end else if (r_up) begin
                if (r_idx != r_last) begin
                    w_nxt_idx = r_idx + ONE;
                end else begin
                    w_nxt_idx = r_idx - ONE;
                    w_nxt_up  = 1'b0;
                end
            end else begin
                if (r_idx != r_first) begin
                    w_nxt_idx = r_idx - ONE;
                end else begin
                    w_nxt_idx = r_idx + ONE;
                    w_nxt_up  = 1'b1;
                end
            end
        end else
`endif
        if (r_idx != r_last) begin
            w_nxt_idx = r_idx + ONE;
        end else if (r_loop) begin
            w_nxt_idx = r_first;
        end else begin
            w_nxt_end = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_first    <= '0;
            r_last     <= '0;
            r_loop     <= 1'b0;
            r_dwell    <= '0;
            r_lat      <= '0;
            r_lut_idx  <= '0;
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_step     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
            r_pp       <= 1'b0;
            r_up       <= 1'b1;
`endif
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            if (abort_i) begin
                r_state    <= S_IDLE;
                r_wr_valid <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_first <= first_idx_i;
                            r_last  <= last_idx_i;
                            r_loop  <= loop_i;
                            r_dwell <= dwell_i;
                            r_idx   <= first_idx_i;
`ifdef DDS_SWEEP_PINGPONG_EN
                            r_pp    <= pingpong_i;
                            r_up    <= 1'b1;
`endif
                            if (first_idx_i > last_idx_i) begin
                                r_err  <= 1'b1;
                                r_done <= 1'b1;
                            end else begin
                                r_err   <= 1'b0;
                                r_busy  <= 1'b1;
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: begin
                        r_lut_idx <= r_idx;
                        r_lat     <= 2'(LUT_LAT);
                        r_state   <= S_WAIT_LUT;
                    end
                    S_WAIT_LUT: begin
                        if (r_lat == 2'd0) begin
                            r_wr_data  <= lut_data_i;
                            r_wr_valid <= 1'b1;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_lat <= r_lat - 2'd1;
                        end
                    end
                    S_ISSUE: begin
                        if (wr.wr_ready_i) begin
                            r_wr_valid <= 1'b0;
                            r_state    <= S_WAIT_DONE;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (wr.frame_done_i) begin
                            r_step <= 1'b1;
                            if (w_has_dwell) begin
                                r_state <= S_DWELL;
                            end
                        end
                    end
                    S_DWELL: begin
                    end
                    default: r_state <= S_IDLE;
                endcase

                if (w_next_step) begin
                    if (w_nxt_end) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= w_nxt_idx;
                        r_state <= S_FETCH;
`ifdef DDS_SWEEP_PINGPONG_EN
                        r_up    <= w_nxt_up;
`endif
                    end
                end
            end
        end
    end

    assign lut_idx_o     = r_lut_idx;
    assign wr.wr_valid_o = r_wr_valid;
    assign wr.wr_data_o  = r_wr_data;
    assign busy_o        = r_busy;
    assign step_o        = r_step;
    assign done_o        = r_done;
    assign err_o         = r_err;

endmodule

// File: doc/dds_sweep_sequencer.md
Name: dds_sweep_sequencer

Overview:
- Upstream stage of the DDS parallel-port write engine.
- Walks a range of frequency-table indices, fetches each 32-bit register word from the frequency LUT, and hands it to the bus engine over a valid/ready handshake.
- Waits for the engine's IO_update completion, then dwells a programmable number of clocks before the next step.
- Replaces the free-running table counter with a controlled, restartable sweep.

Parameters:
- IDXW, 7, width of LUT index.
- DWELLW, 24, width of dwell counter.
- LUT_LAT, 1, LUT read latency in clocks (1..3).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle sweep start pulse
- abort_i  in  1  one-cycle abort pulse
- loop_i  in  1  1 = restart at first_idx_i after last step; sampled on start
- first_idx_i  in  IDXW  first table index; sampled on start
- last_idx_i  in  IDXW  last table index; sampled on start
- dwell_i  in  DWELLW  idle clocks after each frame_done; sampled on start
- lut_idx_o  out  IDXW  registered LUT address
- lut_data_i  in  32  LUT word, valid LUT_LAT clocks after lut_idx_o changes
- wr_valid_o  out  1  write word available to bus engine
- wr_data_o  out  32  write word
- wr_ready_i  in  1  bus engine accepts word
- frame_done_i  in  1  engine pulse at IO_update of accepted word
- busy_o  out  1  sweep in progress
- step_o  out  1  pulse per completed step
- done_o  out  1  pulse at sweep completion
- err_o  out  1  sticky: illegal range; cleared by next legal start

Behaviour:
- Reset and clock: rstn is an asynchronous, active-low reset; all logic runs on clk.
- Reset values: all outputs 0, state IDLE.
- States: IDLE, FETCH, WAIT_LUT, ISSUE, WAIT_DONE, DWELL.
- IDLE + start_i:
  - Latch configuration; idx <= first_idx_i.
  - If first_idx_i > last_idx_i: err_o <= 1, done_o pulses next cycle, stay IDLE, no writes.
  - Otherwise err_o <= 0, busy_o <= 1, go to FETCH.
- start_i while busy_o is ignored.
- FETCH: lut_idx_o <= idx (one cycle), then WAIT_LUT.
- WAIT_LUT: count LUT_LAT clocks, then capture lut_data_i into wr_data_o, set wr_valid_o, go to ISSUE.
  - wr_valid_o first rises LUT_LAT+2 clocks after the start pulse edge.
- ISSUE:
  - wr_valid_o and wr_data_o hold stable until wr_valid_o && wr_ready_i.
  - On that cycle wr_valid_o <= 0, go to WAIT_DONE.
- WAIT_DONE: on frame_done_i, step_o pulses; go to DWELL if dwell != 0, else to next-step.
- frame_done_i in any other state is ignored.
- DWELL: counter runs dwell clocks, then next-step.
- Next-step:
  - idx != last: idx <= idx+1, go to FETCH.
  - idx == last and loop: idx <= first, go to FETCH.
  - Otherwise done_o pulses, busy_o <= 0, go to IDLE.
- Index arithmetic is unsigned IDXW-bit; last = 2^IDXW-1 never wraps, because range end terminates first.
- first == last: a single step repeats each loop iteration, or completes once.
- abort_i, from any state: next cycle IDLE, wr_valid_o = 0, busy_o = 0, no done_o, no step_o.
  - An already-accepted frame's frame_done_i is ignored.
- abort_i and start_i in the same cycle: abort wins, start dropped.
- Reset mid-operation: immediate return to reset values; no partial handshake is preserved.

Optional Feature:
- Macro: DDS_SWEEP_PINGPONG_EN.
- Defined: adds input pingpong_i (sampled on start). When 1 and loop is set, the sweep reverses at last (decrementing to first) and again at first, giving a triangle sweep.
  - The endpoint is issued once per turn, not repeated.
  - first == last degenerates to repeating that single step.
- Undefined: port absent; sawtooth behaviour only.

Decomposition:
- Shared package dds_pkg holds:
  - state enum;
  - IDX_W and DATA_W = 32 constants;
  - a DWELL_NONE constant = 0.
- One natural sub-module, dds_dwell_timer: load/count/expire down-counter used by the DWELL state.
- FSM, index logic and output registers stay in the top.

Test Plan:
- LUT_LAT=1, first=3, last=5, loop=0, dwell=0, engine ready always, frame_done 25 clocks after accept:
  - lut_idx_o sequence 3,4,5;
  - three handshakes with data LUT[3..5];
  - step_o x3, then done_o one clock after the third frame_done.
- Backpressure: hold wr_ready_i=0 for 10 clocks → wr_valid_o stays 1 and wr_data_o is unchanged for all 10; accepted exactly once.
- dwell=100 → next lut_idx_o change occurs exactly 101 clocks after frame_done_i (100 dwell + 1 FETCH).
- loop=1, first=last=7 → repeated writes of LUT[7]; abort mid-ISSUE → wr_valid_o 0 next clock, busy_o 0, no done_o.
- first=9, last=2 → err_o=1, done_o pulse, zero handshakes; a following legal start clears err_o.
- Simultaneous start_i+abort_i in IDLE → remains IDLE; rstn asserted during WAIT_DONE → all outputs 0 asynchronously.
